// File: rtl/fx_denormalize_pkg.sv
// fixed_point_pkg: shared Q5.27 fixed-point types and constants for the vision datapath.
//   FX_WIDTH/FX_INT/FX_FRAC : word layout (5 integer bits, 27 fraction bits)
//   FX_IDX_W                : width of a bit index into an fx_t word
//   fx_t, fx_idx_t          : value and bit-index types
//   denorm_beat_t           : one beat travelling through the denormalizer
//   fx_lead_index           : position of the most significant set bit (0 for a zero word)
package fixed_point_pkg;
    localparam int FX_WIDTH = 32;
    localparam int FX_INT   = 5;
    localparam int FX_FRAC  = 27;
    localparam int FX_IDX_W = $clog2(FX_WIDTH);

    typedef logic [FX_INT-1:-FX_FRAC] fx_t;
    typedef logic [FX_IDX_W-1:0]      fx_idx_t;

    typedef struct packed {
        fx_t     data;
        fx_idx_t shamt;
        logic    sticky;
    } denorm_beat_t;

    function automatic fx_idx_t fx_lead_index(input fx_t x);
        fx_idx_t idx = '0;
        for (int i = 0; i < FX_WIDTH; i++)
            if (x[i-FX_FRAC]) idx = fx_idx_t'(i);
        return idx;
    endfunction
endpackage

// File: rtl/fx_denormalize_if.sv
// fx_denormalize_if: input and output valid/ready streams of the denormalizer.
//   in_valid/in_ready   : input handshake
//   in_mant/in_index    : normalized mantissa and destination bit of its leading one
//   in_zero             : the value is zero (mantissa ignored)
//   out_valid/out_ready : output handshake
//   out_data            : rebuilt fixed-point word
//   out_inexact         : at least one set bit was shifted out
//   master drives the inputs and consumes the result; slave is the denormalizer.
interface fx_denormalize_if
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [IDX_W-1:0] in_index;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_inexact;

    modport master (
        output in_valid, in_mant, in_index, in_zero, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    modport slave (
        input  in_valid, in_mant, in_index, in_zero, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/fx_denormalize_stage.sv
// fx_denorm_stage: one log-shifter stage: conditional right shift by SHIFT plus its pipeline register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid/o_ready     : upstream handshake (o_ready also means "this stage loads this cycle")
//   i_data/i_shamt/i_sticky : incoming beat
//   o_valid/i_ready     : downstream handshake (i_ready = next stage loads this cycle)
//   o_data/o_shamt/o_sticky : registered beat
module fx_denorm_stage #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0] i_shamt,
    input  logic             i_sticky,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [IDX_W-1:0] o_shamt,
    output logic             o_sticky
);
    localparam int BIT = $clog2(SHIFT);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [IDX_W-1:0] r_shamt;
    logic             r_sticky;
    logic             w_load;
    logic             w_take;
    logic [WIDTH-1:0] w_data;
    logic             w_sticky;

    // Loading while empty or while the successor drains us keeps the pipe bubble-free.
    assign w_load   = !r_valid || i_ready;
    assign w_take   = i_shamt[BIT];
    assign w_data   = w_take ? i_data >> SHIFT : i_data;
    assign w_sticky = i_sticky | (w_take & (|i_data[SHIFT-1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_shamt  <= '0;
            r_sticky <= 1'b0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data   <= w_data;
                r_shamt  <= i_shamt;
                r_sticky <= w_sticky;
            end
        end
    end

    assign o_ready  = w_load;
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_shamt  = r_shamt;
    assign o_sticky = r_sticky;
endmodule

// File: rtl/fx_denormalize.sv
// fx_denormalize: pipelined log-shifter that turns a normalized mantissa back into a plain fixed-point word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fx_denormalize_if (input stream in, result stream out)
// Stage k shifts by 2^(IDX_W-1-k) when the matching bit of s = WIDTH-1-index is set; latency IDX_W.
module fx_denormalize
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    fx_denormalize_if.slave     bus
);
    logic             w_valid  [IDX_W+1];
    logic             w_ready  [IDX_W+1];
    logic [WIDTH-1:0] w_data   [IDX_W+1];
    logic [IDX_W-1:0] w_shamt  [IDX_W+1];
    logic             w_sticky [IDX_W+1];
    logic             w_unused_shamt;

    if (WIDTH != (1 << IDX_W)) begin : g_width_check
        $error("fx_denormalize: WIDTH must be a power of two");
    end

    // WIDTH-1-index equals ~index because WIDTH-1 is all ones in IDX_W bits.
    assign w_valid[0]  = bus.in_valid;
    assign w_data[0]   = bus.in_zero ? '0 : bus.in_mant;
    assign w_shamt[0]  = ~bus.in_index;
    assign w_sticky[0] = 1'b0;
    assign bus.in_ready = w_ready[0];

    for (genvar k = 0; k < IDX_W; k++) begin : g_stage
        fx_denorm_stage #(
            .WIDTH(WIDTH),
            .IDX_W(IDX_W),
            .SHIFT(1 << (IDX_W-1-k))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_data  (w_data[k]),
            .i_shamt (w_shamt[k]),
            .i_sticky(w_sticky[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_data  (w_data[k+1]),
            .o_shamt (w_shamt[k+1]),
            .o_sticky(w_sticky[k+1])
        );
    end

    // The last stage's shift amount has been fully consumed.
    assign w_unused_shamt  = ^w_shamt[IDX_W];
    assign w_ready[IDX_W]  = bus.out_ready;
    assign bus.out_valid   = w_valid[IDX_W];
    assign bus.out_data    = w_data[IDX_W];
    assign bus.out_inexact = w_sticky[IDX_W];
endmodule

// File: tb/tb_fx_denormalize.sv
// tb_fx_denormalize: scoreboard bench for fx_denormalize.
module tb_fx_denormalize;
    import fixed_point_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    denorm_beat_t exp_q[$];

    always #5 clk = ~clk;

    fx_denormalize_if #(.WIDTH(FX_WIDTH)) bus ();

    fx_denormalize #(.WIDTH(FX_WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic denorm_beat_t model(input logic [31:0] mant, input fx_idx_t idx, input logic zero);
        denorm_beat_t b;
        int s;
        b = '0;
        s = 31 - int'(idx);
        b.shamt = ~idx;
        if (!zero) begin
            b.data   = mant >> s;
            b.sticky = |(mant & ((32'h1 << s) - 32'h1));
        end
        return b;
    endfunction

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_index = '0; bus.in_zero = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        tests++; if (bus.out_inexact !== 1'b0) begin fails++; $display("FAIL reset_out_inexact got=%b exp=0", bus.out_inexact); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single(input logic [31:0] mant, input fx_idx_t idx, input logic zero);
        denorm_beat_t e;
        int n;
        bus.out_ready = 1'b1;
        bus.in_mant = mant; bus.in_index = idx; bus.in_zero = zero; bus.in_valid = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got=%b exp=1", bus.in_ready); end
        exp_q.push_back(model(mant, idx, zero));
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        tests++; if (n !== 5) begin fails++; $display("FAIL single_latency mant=%h idx=%0d got=%0d exp=5", mant, idx, n); end
        e = exp_q.pop_front();
        tests++;
        if (bus.out_data !== e.data || bus.out_inexact !== e.sticky) begin
            fails++; $display("FAIL single_result mant=%h idx=%0d zero=%b got=%h/%b exp=%h/%b", mant, idx, zero, bus.out_data, bus.out_inexact, e.data, e.sticky);
        end
        @(negedge clk);
    endtask

    task automatic test_directed;
        test_single(32'h8000_0000, 5'd0, 1'b0);
        test_single(32'hC000_0000, 5'd4, 1'b0);
        test_single(32'hC000_0000, 5'd31, 1'b0);
        test_single(32'hFFFF_FFFF, 5'd0, 1'b0);
        test_single(32'hDEAD_BEEF, 5'd9, 1'b1);
        test_single(32'hA5A5_A5A5, 5'd20, 1'b0);
    endtask

    task automatic test_stream(input bit stall);
        int sent = 0, got = 0, cyc = 0, last = -1;
        bit held = 1'b0;
        logic [31:0] pd = '0;
        logic px = 1'b0;
        denorm_beat_t e;
        while ((sent < 8 || got < 8) && cyc < 100) begin
            bus.in_valid = (sent < 8); bus.in_mant = 32'h8000_0000; bus.in_index = fx_idx_t'(sent); bus.in_zero = 1'b0;
            bus.out_ready = !(stall && cyc >= 6 && cyc <= 9);
            #1;
            if (held) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_inexact !== px) begin
                    fails++; $display("FAIL stall_stable cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, bus.out_valid, bus.out_data, bus.out_inexact, pd, px);
                end
            end
            if (stall && cyc == 7) begin
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
                tests++; if (exp_q.size() !== 5) begin fails++; $display("FAIL stall_held got=%0d exp=5", exp_q.size()); end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(32'h8000_0000, fx_idx_t'(sent), 1'b0));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stream_extra got=%h exp=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data || bus.out_inexact !== e.sticky) begin
                        fails++; $display("FAIL stream_data beat=%0d got=%h/%b exp=%h/%b", got, bus.out_data, bus.out_inexact, e.data, e.sticky);
                    end
                end
                if (!stall && got > 0) begin
                    tests++; if (cyc !== last + 1) begin fails++; $display("FAIL stream_gap beat=%0d got=%0d exp=%0d", got, cyc, last + 1); end
                end
                last = cyc;
                got++;
            end
            held = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            px = bus.out_inexact;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        tests++; if (got !== 8) begin fails++; $display("FAIL stream_count got=%0d exp=8", got); end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream;
        int sent = 0, seen = 0;
        bus.out_ready = 1'b0;
        while (sent < 3) begin
            bus.in_valid = 1'b1; bus.in_mant = 32'h8000_0000; bus.in_index = fx_idx_t'(sent + 10); bus.in_zero = 1'b0;
            #1;
            if (bus.in_ready) sent++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL midrst_data got=%h exp=0", bus.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) begin
            #1;
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_stale got=%0d exp=0", seen); end
        exp_q.delete();
        test_single(32'h8000_0000, 5'd2, 1'b0);
    endtask

    task automatic test_random;
        int sent = 0, got = 0, cyc = 0;
        bit acc;
        logic [31:0] x;
        fx_idx_t i;
        denorm_beat_t b = '0, e;
        bus.in_valid = 1'b0;
        while ((sent < 1000 || got < 1000) && cyc < 20000) begin
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                x = $urandom() >> $urandom_range(0, 31);
                if (x == 0) x = 32'h1;
                i = fx_lead_index(x);
                bus.in_mant = x << (31 - int'(i)); bus.in_index = i; bus.in_zero = 1'b0; bus.in_valid = 1'b1;
                b.data = x; b.shamt = ~i; b.sticky = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin exp_q.push_back(b); sent++; end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL random_extra got=%h exp=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data || bus.out_inexact !== e.sticky) begin
                        fails++; $display("FAIL random_roundtrip beat=%0d got=%h/%b exp=%h/%b", got, bus.out_data, bus.out_inexact, e.data, e.sticky);
                    end
                end
                got++;
            end
            @(negedge clk);
            cyc++;
            if (acc) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        tests++; if (got !== 1000) begin fails++; $display("FAIL random_count got=%0d exp=1000", got); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(1'b0);
        test_stream(1'b1);
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
